// File: rtl/mem_sram_bridge.sv
// Responder for the CPU memory request interface: splits 16-bit word requests into two byte accesses on an async 8-bit SRAM.
// Optional single-byte accesses are enabled by defining MEM_SRAM_BRIDGE_BYTE_EN (adds the bem input).
module mem_sram_bridge #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rqm_n,
    input  logic        rwm_n,
    input  logic [19:0] adm_n,
    input  logic [15:0] dwm_n,
`ifdef MEM_SRAM_BRIDGE_BYTE_EN
    input  logic        bem,
`endif
    output logic        akm_n,
    output logic [15:0] drm_n,
    output logic [19:0] sram_a,
    input  logic [7:0]  sram_dq_i,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        LO_SU,
        LO_ST,
        HI_SU,
        HI_ST,
        ACK,
        RTZ
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [19:0] base_addr;
    logic [15:0] wdata;
    logic [7:0]  lo_byte;
    logic [3:0]  wait_cnt;
    logic        is_read;
    logic        byte_mode;
    logic [19:0] req_addr;
    logic        req_byte;

    // Word accesses are forced even; a byte access keeps the exact address.
    always_comb begin
        req_byte = 1'b0;
`ifdef MEM_SRAM_BRIDGE_BYTE_EN
        req_byte = bem;
`endif
        req_addr = req_byte ? adm_n : (adm_n & 20'hFFFFE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            base_addr  <= 20'h0;
            wdata      <= 16'h0;
            lo_byte    <= 8'h0;
            wait_cnt   <= 4'h0;
            is_read    <= 1'b0;
            byte_mode  <= 1'b0;
            akm_n      <= 1'b0;
            drm_n      <= 16'h0;
            sram_a     <= 20'h0;
            sram_dq_o  <= 8'h0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
        end else begin
            akm_n <= 1'b0;
            case (state)
                IDLE: begin
                    if (rqm_n) begin
                        base_addr  <= req_addr;
                        wdata      <= dwm_n;
                        is_read    <= rwm_n;
                        byte_mode  <= req_byte;
                        sram_a     <= req_addr;
                        sram_ce_n  <= 1'b0;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_o  <= dwm_n[7:0];
                        sram_dq_oe <= ~rwm_n;
                        state      <= LO_SU;
                    end
                end

                LO_SU: begin
                    wait_cnt <= WAIT_LOAD;
                    if (is_read) sram_oe_n <= 1'b0;
                    else         sram_we_n <= 1'b0;
                    state <= LO_ST;
                end

                // The low byte is captured on the final strobe edge, as oe_n rises.
                LO_ST: begin
                    if (wait_cnt != 4'h0) begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end else begin
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (is_read) lo_byte <= sram_dq_i;
                        if (byte_mode) begin
                            sram_ce_n  <= 1'b1;
                            sram_dq_oe <= 1'b0;
                            akm_n      <= 1'b1;
                            if (is_read) drm_n <= {8'h00, sram_dq_i};
                            state <= ACK;
                        end else begin
                            sram_a    <= base_addr + 20'd1;
                            sram_dq_o <= wdata[15:8];
                            state     <= HI_SU;
                        end
                    end
                end

                HI_SU: begin
                    wait_cnt <= WAIT_LOAD;
                    if (is_read) sram_oe_n <= 1'b0;
                    else         sram_we_n <= 1'b0;
                    state <= HI_ST;
                end

                HI_ST: begin
                    if (wait_cnt != 4'h0) begin
                        wait_cnt <= wait_cnt - 4'h1;
                    end else begin
                        sram_ce_n  <= 1'b1;
                        sram_oe_n  <= 1'b1;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        akm_n      <= 1'b1;
                        if (is_read) drm_n <= {sram_dq_i, lo_byte};
                        state <= ACK;
                    end
                end

                // Return-to-zero: a request still held after ack is not serviced twice.
                ACK: state <= rqm_n ? RTZ : IDLE;

                RTZ: if (!rqm_n) state <= IDLE;

                default: state <= IDLE;
            endcase
        end
    end

endmodule
